seg_display_scan: RTL and testbench
===================================

// Module: seg_display_scan
// PURPOSE
//  Output-side counterpart to the key input path. Takes a binary value, converts it
//  to 4 BCD digits with an iterative shift-add-3 (double dabble) engine, then drives
//  one shared active-low 7-seg bus with per-digit anode select, time-multiplexed.
//  Sits between stopwatch/counter logic and board pins.
// PARAMETERS
//  CLOCK_FRQ  50000000  clk frequency, Hz
//  SCAN_HZ    1000      digit switch rate, Hz; SCAN_DIV = CLOCK_FRQ/SCAN_HZ (>=2)
//  WIDTH      14        value width; conversion takes WIDTH shift cycles
// PORTS
//  clk       in   1      system clock
//  rst       in   1      async reset, active-low (0 = reset)
//  value     in   WIDTH  binary value to display, sampled on load
//  load      in   1      1-cycle strobe; accepted only when busy=0
//  blank_lz  in   1      1 = blank leading zeros (digit 0 never blanked)
//  dp_mask   in   4      bit i = light decimal point on digit i, live (not latched)
//  busy      out  1      conversion in progress
//  overflow  out  1      last accepted value > 9999
//  seg       out  7      segments g..a, active-low
//  dp        out  1      decimal point, active-low
//  an        out  4      anode select, active-low one-hot, an[0] = rightmost digit
// BEHAVIOUR
//  Reset (rst=0, async): seg=7'h7F, dp=1, an=4'hF, busy=0, overflow=0, shown digits
//   0, scan idx 0, divider 0, FSM IDLE. Releasing rst mid-conversion leaves nothing
//   committed.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: load=1 at edge k -> capture value (saturate: value>9999 -> 9999, set
//    ovf_pend), clear BCD shift reg, cnt=0, busy=1 after edge k, -> SHIFT.
//   SHIFT: each edge, add 3 to every BCD nibble >=5, then shift left 1 with the next
//    binary MSB; cnt++; after WIDTH shifts (edges k+1..k+WIDTH) -> DONE.
//   DONE: edge k+WIDTH+1 commits all 4 digits and overflow=ovf_pend atomically;
//    busy=0; -> IDLE. busy is high exactly WIDTH+1 cycles.
//   load while busy=1 (SHIFT or DONE): ignored, no queueing.
//   Display never shows partial results; old digits stay until commit.
//  Scan: divider counts 0..SCAN_DIV-1; at terminal count divider->0 and idx=idx+1
//   mod 4 (3 wraps to 0). seg, dp and an are registered and update on that same edge.
//   an = ~(4'b1 << idx).
//  Segment code, active-low: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//  Blanking: if blank_lz=1 and idx>0 and digit[idx] and all higher digits are 0,
//   then seg=7'h7F. an still selects the digit. dp = ~dp_mask[idx], never blanked.
//  Simultaneous load and scan tick: independent; the commit edge and the idx-change
//   edge may coincide, and the new digit is then shown on that edge.
// TESTING
//  1 Hold rst=0 -> seg=7F, an=F, busy=0. Release; SCAN_DIV=4 -> an sequence
//    E,D,B,7,E, changing every 4 cycles.
//  2 load value=1234 -> busy=1 for 15 cycles, overflow=0; an=E shows seg=0011001,
//    an=7 shows seg=1111001.
//  3 load 10000 -> overflow=1 and all digits 0010000 (9999); then load 5 ->
//    overflow=0, digit0 shows 0010010.
//  4 blank_lz=1, load 7 -> digits 3..1 seg=7F, digit0 seg=1111000; load 0 -> digit0
//    seg=1000000; dp_mask=4'b0010 -> dp=0 only while an=D.
//  5 load 1234, then load 42 on the 3rd busy cycle -> second load ignored, display
//    1234, busy falls on the original schedule.
//  6 Display 1234, load 56, assert rst after 7 shifts -> outputs go to reset values
//    immediately; after release, digits are 0 and busy=0.

Source files
------------

// File: rtl/seg_display_scan.sv
// Binary-to-BCD (shift-add-3) converter driving a time-multiplexed, active-low
// 4-digit 7-segment display with leading-zero blanking and live decimal points.
module seg_display_scan #(
    parameter int unsigned CLOCK_FRQ = 50000000,
    parameter int unsigned SCAN_HZ   = 1000,
    parameter int unsigned WIDTH     = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic             blank_lz,
    input  logic [3:0]       dp_mask,
    output logic             busy,
    output logic             overflow,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [3:0]       an
);

    localparam int unsigned SCAN_DIV = CLOCK_FRQ / SCAN_HZ;
    localparam int unsigned DIV_W    = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] bin_q, bin_n;
    logic [15:0]      bcd_q, bcd_n, bcd_adj;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             ovf_pend_q, ovf_pend_n;
    logic [15:0]      digits_q, digits_n;
    logic             overflow_q, overflow_n;
    logic             value_big;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q;
    logic             tick;
    logic [3:0]       cur_digit;
    logic             lead_zero;
    logic [6:0]       seg_q, seg_n;
    logic             dp_q, dp_n;
    logic [3:0]       an_q, an_n;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    assign value_big = (32'(value) > 32'd9999);

    always_comb begin
        state_n    = state_q;
        bin_n      = bin_q;
        bcd_n      = bcd_q;
        cnt_n      = cnt_q;
        ovf_pend_n = ovf_pend_q;
        digits_n   = digits_q;
        overflow_n = overflow_q;
        bcd_adj    = bcd_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_n      = value_big ? WIDTH'(9999) : value;
                    ovf_pend_n = value_big;
                    bcd_n      = '0;
                    cnt_n      = '0;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (bcd_adj[4*i +: 4] >= 4'd5)
                        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
                end
                bcd_n = {bcd_adj[14:0], bin_q[WIDTH-1]};
                bin_n = bin_q << 1;
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1))
                    state_n = DONE;
            end
            DONE: begin
                digits_n   = bcd_q;
                overflow_n = ovf_pend_q;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            bin_q      <= bin_n;
            bcd_q      <= bcd_n;
            cnt_q      <= cnt_n;
            ovf_pend_q <= ovf_pend_n;
            digits_q   <= digits_n;
            overflow_q <= overflow_n;
        end
    end

    // Scan slot decode uses digits_n so a commit coinciding with a scan tick shows at once.
    assign tick = (div_q == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        cur_digit = digits_n[3:0];
        lead_zero = 1'b0;
        case (idx_q)
            2'd0: begin
                cur_digit = digits_n[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                cur_digit = digits_n[7:4];
                lead_zero = (digits_n[15:4] == '0);
            end
            2'd2: begin
                cur_digit = digits_n[11:8];
                lead_zero = (digits_n[15:8] == '0);
            end
            default: begin
                cur_digit = digits_n[15:12];
                lead_zero = (digits_n[15:12] == '0);
            end
        endcase
        seg_n = (blank_lz && lead_zero) ? 7'h7F : seg_code(cur_digit);
        dp_n  = ~dp_mask[idx_q];
        an_n  = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= 4'hF;
        end else if (tick) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
            seg_q <= seg_n;
            dp_q  <= dp_n;
            an_q  <= an_n;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with a 4-cycle scan divider; expected
// segment/anode patterns are hand-computed constants.
module tb_seg_display_scan;

    localparam int unsigned WIDTH = 14;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] value;
    logic             load;
    logic             blank_lz;
    logic [3:0]       dp_mask;
    logic             busy;
    logic             overflow;
    logic [6:0]       seg;
    logic             dp;
    logic [3:0]       an;

    int vectors = 0;
    int errors  = 0;

    seg_display_scan #(
        .CLOCK_FRQ(4),
        .SCAN_HZ  (1),
        .WIDTH    (WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .blank_lz(blank_lz),
        .dp_mask (dp_mask),
        .busy    (busy),
        .overflow(overflow),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for a freshly latched scan slot selecting the target anode.
    task automatic wait_fresh(input logic [3:0] target);
        int n;
        n = 0;
        while (an === target && n < 8) begin
            step();
            n++;
        end
        while (an !== target && n < 24) begin
            step();
            n++;
        end
        chk("an_reach", {4'h0, an}, {4'h0, target});
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (WIDTH + 1) step();
    endtask

    initial begin
        rst      = 1'b0;
        value    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;

        // 1: reset values and scan order
        step();
        step();
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_busy", {7'h0, busy}, 8'h00);
        chk("rst_ovf", {7'h0, overflow}, 8'h00);
        chk("rst_dp", {7'h0, dp}, 8'h01);
        rst = 1'b1;
        repeat (3) step();
        chk("scan_pre", {4'h0, an}, 8'h0F);
        step();
        chk("scan_0", {4'h0, an}, 8'h0E);
        repeat (3) step();
        chk("scan_hold0", {4'h0, an}, 8'h0E);
        step();
        chk("scan_1", {4'h0, an}, 8'h0D);
        repeat (4) step();
        chk("scan_2", {4'h0, an}, 8'h0B);
        repeat (4) step();
        chk("scan_3", {4'h0, an}, 8'h07);
        repeat (4) step();
        chk("scan_wrap", {4'h0, an}, 8'h0E);

        // 2: load 1234, busy exactly 15 cycles
        value = 14'd1234;
        load  = 1'b1;
        step();
        load  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("busy_hi", {7'h0, busy}, 8'h01);
            step();
        end
        chk("busy_lo", {7'h0, busy}, 8'h00);
        chk("ovf_1234", {7'h0, overflow}, 8'h00);
        wait_fresh(4'hE);
        chk("d0_1234", {1'b0, seg}, {1'b0, 7'b0011001});
        wait_fresh(4'hD);
        chk("d1_1234", {1'b0, seg}, {1'b0, 7'b0110000});
        wait_fresh(4'hB);
        chk("d2_1234", {1'b0, seg}, {1'b0, 7'b0100100});
        wait_fresh(4'h7);
        chk("d3_1234", {1'b0, seg}, {1'b0, 7'b1111001});

        // 3: saturation and overflow clear
        do_load(14'd10000);
        chk("ovf_set", {7'h0, overflow}, 8'h01);
        wait_fresh(4'hE);
        chk("sat_d0", {1'b0, seg}, {1'b0, 7'b0010000});
        wait_fresh(4'hD);
        chk("sat_d1", {1'b0, seg}, {1'b0, 7'b0010000});
        wait_fresh(4'hB);
        chk("sat_d2", {1'b0, seg}, {1'b0, 7'b0010000});
        wait_fresh(4'h7);
        chk("sat_d3", {1'b0, seg}, {1'b0, 7'b0010000});
        do_load(14'd5);
        chk("ovf_clr", {7'h0, overflow}, 8'h00);
        wait_fresh(4'hE);
        chk("d0_5", {1'b0, seg}, {1'b0, 7'b0010010});
        wait_fresh(4'hB);
        chk("d2_5_nob", {1'b0, seg}, {1'b0, 7'b1000000});

        // 4: leading-zero blanking and decimal point
        blank_lz = 1'b1;
        do_load(14'd7);
        wait_fresh(4'hE);
        chk("lz7_d0", {1'b0, seg}, {1'b0, 7'b1111000});
        wait_fresh(4'hD);
        chk("lz7_d1", {1'b0, seg}, 8'h7F);
        wait_fresh(4'hB);
        chk("lz7_d2", {1'b0, seg}, 8'h7F);
        wait_fresh(4'h7);
        chk("lz7_d3", {1'b0, seg}, 8'h7F);
        do_load(14'd0);
        wait_fresh(4'hE);
        chk("lz0_d0", {1'b0, seg}, {1'b0, 7'b1000000});
        wait_fresh(4'hD);
        chk("lz0_d1", {1'b0, seg}, 8'h7F);
        dp_mask = 4'b0010;
        wait_fresh(4'hD);
        chk("dp_on", {7'h0, dp}, 8'h00);
        wait_fresh(4'hB);
        chk("dp_off_b", {7'h0, dp}, 8'h01);
        wait_fresh(4'hE);
        chk("dp_off_e", {7'h0, dp}, 8'h01);
        dp_mask  = 4'b0000;
        blank_lz = 1'b0;

        // 5: load while busy is ignored
        value = 14'd1234;
        load  = 1'b1;
        step();
        load  = 1'b0;
        step();
        step();
        value = 14'd42;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (11) step();
        chk("ign_busy14", {7'h0, busy}, 8'h01);
        step();
        chk("ign_busy15", {7'h0, busy}, 8'h00);
        step();
        chk("ign_norest", {7'h0, busy}, 8'h00);
        wait_fresh(4'hD);
        chk("ign_d1", {1'b0, seg}, {1'b0, 7'b0110000});
        wait_fresh(4'hE);
        chk("ign_d0", {1'b0, seg}, {1'b0, 7'b0011001});

        // 6: async reset mid-conversion
        value = 14'd56;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (7) step();
        rst = 1'b0;
        #1;
        chk("mrst_seg", {1'b0, seg}, 8'h7F);
        chk("mrst_an", {4'h0, an}, 8'h0F);
        chk("mrst_dp", {7'h0, dp}, 8'h01);
        chk("mrst_busy", {7'h0, busy}, 8'h00);
        step();
        rst = 1'b1;
        step();
        chk("post_busy", {7'h0, busy}, 8'h00);
        chk("post_ovf", {7'h0, overflow}, 8'h00);
        wait_fresh(4'hE);
        chk("post_d0", {1'b0, seg}, {1'b0, 7'b1000000});
        wait_fresh(4'hD);
        chk("post_d1", {1'b0, seg}, {1'b0, 7'b1000000});
        chk("post_busy2", {7'h0, busy}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
